count_monitor: RTL and testbench

Sequence checker that sits on the output of the team's 4-bit free-running up-counter and confirms it steps by +1 modulo 2^WIDTH. It samples the counter value on enabled cycles, locks after a run of correct steps, flags each break in the sequence, and keeps a saturating error tally. It is instantiated beside the counter in lab top-levels and benches, so counter faults become visible without waveform inspection.

---
 rtl/count_mon_pkg.sv | 25 ++
 rtl/count_monitor_sat_counter.sv | 23 ++
 rtl/count_monitor.sv | 116 +++++++++++
 tb/tb_count_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and defaults for the count_monitor sequence checker.
// Holds the FSM state encoding and the modular increment used for prediction.
package count_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_e;

    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned LOCK_CNT_DEF = 4;
    localparam int unsigned ERR_W_DEF    = 8;

    // x+1 truncated to w bits; callers narrow the result to their own width.
    function automatic logic [31:0] next_count(input logic [31:0] x, input int unsigned w);
        logic [31:0] mask;
        if (w >= 32)
            mask = '1;
        else
            mask = (32'd1 << w) - 32'd1;
        return (x + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
// Used for the monitor's error tally; reusable for any event count.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst)
            r_value <= '0;
        else if (inc && (r_value != '1))
            r_value <= r_value + 1'b1;
    end

    assign value = r_value;

endmodule

// File: rtl/count_monitor.sv
// Checks that a sampled counter steps by +1 modulo 2^WIDTH; locks after a run
// of good steps, pulses err on a break while locked, and tallies breaks.
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
    parameter int unsigned ERR_W    = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] expected
);

    localparam logic [3:0] LOCK_VAL = 4'(LOCK_CNT);

    state_e           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_run_cnt;
    logic             r_locked;
    logic             r_err;
    logic             r_wrap;
    logic [WIDTH-1:0] r_expected;

    state_e           w_state_next;
    logic [WIDTH-1:0] w_prev_next;
    logic [3:0]       w_run_next;
    logic [3:0]       w_run_inc;
    logic             w_err_next;
    logic             w_wrap_next;
    logic             w_match;
    logic [WIDTH-1:0] w_prev_inc;
    logic [WIDTH-1:0] w_expected_next;
    logic [ERR_W-1:0] w_err_cnt;

    assign w_prev_inc      = WIDTH'(next_count(32'(r_prev), WIDTH));
    assign w_expected_next = WIDTH'(next_count(32'(w_prev_next), WIDTH));
    assign w_match         = (q == w_prev_inc);
    assign w_run_inc       = r_run_cnt + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_prev_next  = r_prev;
        w_run_next   = r_run_cnt;
        w_err_next   = 1'b0;
        w_wrap_next  = 1'b0;
        if (en) begin
            w_prev_next = q;
            unique case (r_state)
                IDLE: begin
                    w_run_next   = '0;
                    w_state_next = SYNC;
                end
                SYNC: begin
                    if (w_match) begin
                        w_run_next = w_run_inc;
                        if (w_run_inc == LOCK_VAL)
                            w_state_next = LOCKED;
                    end else begin
                        w_run_next = '0;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_wrap_next = (r_prev == '1);
                    end else begin
                        w_err_next   = 1'b1;
                        w_run_next   = '0;
                        w_state_next = SYNC;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prev     <= '0;
            r_run_cnt  <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_expected <= WIDTH'(1);
        end else begin
            r_state    <= w_state_next;
            r_prev     <= w_prev_next;
            r_run_cnt  <= w_run_next;
            r_locked   <= (w_state_next == LOCKED);
            r_err      <= w_err_next;
            r_wrap     <= w_wrap_next;
            r_expected <= w_expected_next;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err_next),
        .value (w_err_cnt)
    );

    assign locked   = r_locked;
    assign err      = r_err;
    assign wrap     = r_wrap;
    assign err_cnt  = w_err_cnt;
    assign expected = r_expected;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock, wrap, glitch, gated sampling,
// stuck-at-zero, mid-run reset, and error-counter saturation (ERR_W=2 copy).
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst, en, rst2, en2;
    logic [3:0] q, q2;
    logic       locked, err, wrap, locked2, err2, wrap2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    logic [3:0] expected, expected2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_monitor u_dut (
        .clk(clk), .rst(rst), .en(en), .q(q),
        .locked(locked), .err(err), .wrap(wrap),
        .err_cnt(err_cnt), .expected(expected)
    );

    count_monitor #(.ERR_W(2)) u_dut_sat (
        .clk(clk), .rst(rst2), .en(en2), .q(q2),
        .locked(locked2), .err(err2), .wrap(wrap2),
        .err_cnt(err_cnt2), .expected(expected2)
    );

    task automatic step(input logic e, input logic [3:0] v);
        en = e; q = v;
        @(posedge clk); #1;
    endtask

    task automatic step2(input logic e, input logic [3:0] v);
        en2 = e; q2 = v;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst2 = 1'b1; en = 1'b1; q = 4'd7; en2 = 1'b0; q2 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0; en = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (expected !== 4'd1) begin errors++; $display("FAIL reset_expected got %0d want 1", expected); end
        checks++; if (err_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_err_cnt2 got %0d want 0", err_cnt2); end
    endtask

    task automatic test_lock;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'(i));
            checks++; if (locked !== (i == 4)) begin errors++; $display("FAIL lock_seq q=%0d got %b want %b", i, locked, (i == 4)); end
        end
        checks++; if (expected !== 4'd5) begin errors++; $display("FAIL lock_expected got %0d want 5", expected); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_wrap;
        for (int i = 5; i <= 14; i++) step(1'b1, 4'(i));
        step(1'b1, 4'd15);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_early got %b want 0", wrap); end
        step(1'b1, 4'd0);
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b want 1", wrap); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b want 0", err); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got %b want 1", locked); end
        checks++; if (expected !== 4'd1) begin errors++; $display("FAIL wrap_expected got %0d want 1", expected); end
        step(1'b1, 4'd1);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
    endtask

    task automatic test_glitch;
        for (int i = 2; i <= 5; i++) step(1'b1, 4'(i));
        step(1'b1, 4'd9);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL glitch_err got %b want 1", err); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_err_cnt got %0d want 1", err_cnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL glitch_unlock got %b want 0", locked); end
        for (int i = 10; i <= 13; i++) begin
            step(1'b1, 4'(i));
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL glitch_sync_err q=%0d got %b want 0", i, err); end
            checks++; if (locked !== (i == 13)) begin errors++; $display("FAIL glitch_relock q=%0d got %b want %b", i, locked, (i == 13)); end
        end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_err_cnt_hold got %0d want 1", err_cnt); end
    endtask

    task automatic test_gated;
        logic       e_v[9]   = '{1, 0, 1, 0, 1, 0, 0, 1, 1};
        logic [3:0] q_v[9]   = '{14, 14, 15, 15, 0, 0, 7, 1, 2};
        logic       w_v[9]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [3:0] x_v[9]   = '{15, 15, 0, 0, 1, 1, 1, 2, 3};
        for (int i = 0; i < 9; i++) begin
            step(e_v[i], q_v[i]);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL gated_err step=%0d got %b want 0", i, err); end
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gated_locked step=%0d got %b want 1", i, locked); end
            checks++; if (wrap !== w_v[i]) begin errors++; $display("FAIL gated_wrap step=%0d got %b want %b", i, wrap, w_v[i]); end
            checks++; if (expected !== x_v[i]) begin errors++; $display("FAIL gated_expected step=%0d got %0d want %0d", i, expected, x_v[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_stuck;
        step(1'b1, 4'd0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stuck_err got %b want 1", err); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL stuck_wrap got %b want 0", wrap); end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL stuck_err_cnt got %0d want 2", err_cnt); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd0);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL stuck_repeat_err n=%0d got %b want 0", i, err); end
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stuck_locked n=%0d got %b want 0", i, locked); end
        end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL stuck_err_cnt_hold got %0d want 2", err_cnt); end
    endtask

    task automatic test_reset_mid;
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i));
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_prelock got %b want 1", locked); end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL mid_pre_err_cnt got %0d want 2", err_cnt); end
        rst = 1'b1;
        step(1'b1, 4'd9);
        rst = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %b want 0", locked); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err_cnt got %0d want 0", err_cnt); end
        checks++; if (expected !== 4'd1) begin errors++; $display("FAIL mid_expected got %0d want 1", expected); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
        step(1'b1, 4'd7);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_first_err got %b want 0", err); end
        checks++; if (expected !== 4'd8) begin errors++; $display("FAIL mid_first_expected got %0d want 8", expected); end
        step(1'b1, 4'd3);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_sync_err got %b want 0", err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_sync_err_cnt got %0d want 0", err_cnt); end
        en = 1'b0;
    endtask

    task automatic test_saturation;
        logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [3:0] cur;
        cur = 4'd0;
        step2(1'b1, cur);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                cur = cur + 4'd1;
                step2(1'b1, cur);
            end
            checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_lock round=%0d got %b want 1", k, locked2); end
            cur = cur + 4'd5;
            step2(1'b1, cur);
            checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL sat_err round=%0d got %b want 1", k, err2); end
            checks++; if (err_cnt2 !== want[k]) begin errors++; $display("FAIL sat_err_cnt round=%0d got %0d want %0d", k, err_cnt2, want[k]); end
        end
        en2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0; q = '0; q2 = '0;
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_gated();
        test_stuck();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
